sym_framer: RTL and testbench

SYM_FRAMER -- requirements
Module: sym_framer

---
 rtl/sym_framer_pkg.sv | 18 +
 rtl/sym_deser8.sv | 42 ++++
 rtl/sym_framer.sv | 161 ++++++++++++++++
 tb/tb_sym_framer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sym_framer_pkg.sv
// Shared CDR framer definitions: hunt/verify/locked state encodings
// and the soft-decision codes that mark a symbol as weak.
package sym_framer_pkg;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'b00,
        ST_VERIFY = 2'b01,
        ST_LOCKED = 2'b10
    } fr_state_e;

    localparam logic [1:0] Q2_WEAK_LO = 2'b01;
    localparam logic [1:0] Q2_WEAK_HI = 2'b10;

    function automatic logic is_weak(input logic [1:0] q2);
        return (q2 == Q2_WEAK_LO) || (q2 == Q2_WEAK_HI);
    endfunction

endpackage

// File: rtl/sym_deser8.sv
// Symbol deserialiser: 8-bit data and weak-flag shift registers plus
// the bit-in-byte counter that flags the byte-complete strobe.
module sym_deser8
    import sym_framer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_sample_en,
    input  logic       i_d_bb,
    input  logic [1:0] i_d_q2,
    input  logic       i_cnt_clr,
    output logic [7:0] o_sreg,
    output logic [7:0] o_wk,
    output logic [7:0] o_nsreg,
    output logic [7:0] o_nwk,
    output logic       o_byte_done
);

    logic [7:0] r_sreg;
    logic [7:0] r_wk;
    logic [2:0] r_bit_cnt;

    assign o_sreg      = r_sreg;
    assign o_wk        = r_wk;
    assign o_nsreg     = {r_sreg[6:0], i_d_bb};
    assign o_nwk       = {r_wk[6:0], is_weak(i_d_q2)};
    assign o_byte_done = i_sample_en && !i_cnt_clr && (r_bit_cnt == 3'd7);

    // bit counter wraps 7->0 naturally; held at 0 while hunting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sreg    <= 8'h00;
            r_wk      <= 8'h00;
            r_bit_cnt <= 3'd0;
        end else if (i_sample_en) begin
            r_sreg    <= o_nsreg;
            r_wk      <= o_nwk;
            r_bit_cnt <= i_cnt_clr ? 3'd0 : r_bit_cnt + 3'd1;
        end
    end

endmodule

// File: rtl/sym_framer.sv
// Byte framer: hunts for the sync word, verifies it over several frames,
// then emits payload bytes with start-of-frame and weak-symbol flags.
module sym_framer
    import sym_framer_pkg::*;
#(
    parameter logic [7:0] SYNC_WORD  = 8'hA5,
    parameter int         FRAME_LEN  = 16,
    parameter int         VERIFY_CNT = 3,
    parameter int         LOSS_CNT   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_en,
    input  logic       d_bb,
    input  logic [1:0] d_q2,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       sof,
    output logic       byte_weak,
    output logic       locked,
    output logic [1:0] state,
    output logic [7:0] frame_err_cnt
);

    localparam logic [7:0] LP_LAST = 8'(FRAME_LEN - 1);
    localparam logic [7:0] LP_VCNT = 8'(VERIFY_CNT);
    localparam logic [7:0] LP_LCNT = 8'(LOSS_CNT);

    fr_state_e  r_state, w_state_nxt;
    logic [7:0] r_byte_cnt, w_byte_nxt;
    logic [7:0] r_hit_cnt, w_hit_nxt;
    logic [7:0] r_miss_cnt, w_miss_nxt;
    logic [7:0] r_ferr, w_ferr_nxt;
    logic       r_pend_valid, w_pend_valid;
    logic       r_pend_sof, w_pend_sof;
    logic [7:0] r_dout;
    logic       r_valid, r_sof, r_weak, r_locked;

    logic [7:0] w_sreg, w_wk, w_nsreg, w_nwk;
    logic [7:0] w_slot_nxt;
    logic       w_byte_done, w_sync_hit, w_sync_slot;

    sym_deser8 u_deser (
        .clk         (clk),
        .rst         (rst),
        .i_sample_en (sample_en),
        .i_d_bb      (d_bb),
        .i_d_q2      (d_q2),
        .i_cnt_clr   (r_state == ST_HUNT),
        .o_sreg      (w_sreg),
        .o_wk        (w_wk),
        .o_nsreg     (w_nsreg),
        .o_nwk       (w_nwk),
        .o_byte_done (w_byte_done)
    );

    assign w_sync_hit  = (w_nsreg == SYNC_WORD);
    assign w_sync_slot = (r_byte_cnt == 8'd0);
    assign w_slot_nxt  = (r_byte_cnt == LP_LAST) ? 8'd0 : r_byte_cnt + 8'd1;

    always_comb begin
        w_state_nxt  = r_state;
        w_byte_nxt   = r_byte_cnt;
        w_hit_nxt    = r_hit_cnt;
        w_miss_nxt   = r_miss_cnt;
        w_ferr_nxt   = r_ferr;
        w_pend_valid = 1'b0;
        w_pend_sof   = 1'b0;
        unique case (r_state)
            ST_HUNT: begin
                if (sample_en && w_sync_hit) begin
                    w_state_nxt = (LP_VCNT == 8'd1) ? ST_LOCKED : ST_VERIFY;
                    w_byte_nxt  = 8'd1;
                    w_hit_nxt   = 8'd1;
                    w_miss_nxt  = 8'd0;
                end
            end
            ST_VERIFY: begin
                if (w_byte_done) begin
                    w_byte_nxt = w_slot_nxt;
                    if (w_sync_slot && w_sync_hit) begin
                        w_hit_nxt = r_hit_cnt + 8'd1;
                        if (w_hit_nxt == LP_VCNT) begin
                            w_state_nxt = ST_LOCKED;
                            w_miss_nxt  = 8'd0;
                        end
                    end else if (w_sync_slot) begin
                        w_state_nxt = ST_HUNT;
                        w_hit_nxt   = 8'd0;
                    end
                end
            end
            ST_LOCKED: begin
                if (w_byte_done) begin
                    w_byte_nxt = w_slot_nxt;
                    if (w_sync_slot && w_sync_hit) begin
                        w_miss_nxt = 8'd0;
                    end else if (w_sync_slot) begin
                        w_miss_nxt = r_miss_cnt + 8'd1;
                        if (r_ferr != 8'hFF)
                            w_ferr_nxt = r_ferr + 8'd1;
                        if (w_miss_nxt == LP_LCNT)
                            w_state_nxt = ST_HUNT;
                    end else begin
                        w_pend_valid = 1'b1;
                        w_pend_sof   = (r_byte_cnt == 8'd1);
                    end
                end
            end
            default: w_state_nxt = ST_HUNT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_HUNT;
            r_byte_cnt <= 8'd0;
            r_hit_cnt  <= 8'd0;
            r_miss_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_byte_cnt <= w_byte_nxt;
            r_hit_cnt  <= w_hit_nxt;
            r_miss_cnt <= w_miss_nxt;
        end
    end

    // payload is presented one clk after its completing strobe edge,
    // taken from the already-shifted byte register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ferr       <= 8'd0;
            r_pend_valid <= 1'b0;
            r_pend_sof   <= 1'b0;
            r_dout       <= 8'h00;
            r_valid      <= 1'b0;
            r_sof        <= 1'b0;
            r_weak       <= 1'b0;
            r_locked     <= 1'b0;
        end else begin
            r_ferr       <= w_ferr_nxt;
            r_pend_valid <= w_pend_valid;
            r_pend_sof   <= w_pend_sof;
            r_valid      <= r_pend_valid;
            r_sof        <= r_pend_sof;
            r_weak       <= r_pend_valid && (|w_wk);
            r_locked     <= (w_state_nxt == ST_LOCKED);
            if (r_pend_valid)
                r_dout <= w_sreg;
        end
    end

    assign data_out      = r_dout;
    assign data_valid    = r_valid;
    assign sof           = r_sof;
    assign byte_weak     = r_weak;
    assign locked        = r_locked;
    assign state         = r_state;
    assign frame_err_cnt = r_ferr;

endmodule

// File: tb/tb_sym_framer.sv
// Bench for sym_framer: directed acquisition/loss/weak/reset scenarios
// plus random frames, all checked against a bit-position reference model.
module tb_sym_framer;

    localparam int         FL = 4;
    localparam int         VC = 3;
    localparam int         LC = 2;
    localparam logic [7:0] SW = 8'hA5;

    logic       clk = 1'b0;
    logic       rst;
    logic       sample_en;
    logic       d_bb;
    logic [1:0] d_q2;
    logic [7:0] data_out;
    logic       data_valid;
    logic       sof;
    logic       byte_weak;
    logic       locked;
    logic [1:0] state;
    logic [7:0] frame_err_cnt;

    always #5 clk = ~clk;

    sym_framer #(
        .SYNC_WORD  (SW),
        .FRAME_LEN  (FL),
        .VERIFY_CNT (VC),
        .LOSS_CNT   (LC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sample_en     (sample_en),
        .d_bb          (d_bb),
        .d_q2          (d_q2),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .sof           (sof),
        .byte_weak     (byte_weak),
        .locked        (locked),
        .state         (state),
        .frame_err_cnt (frame_err_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    // model: mode 0 hunt, 1 verify, 2 locked; m_pos = bits since sync end
    int         m_mode, m_pos, m_hits, m_miss, m_ferr;
    logic [7:0] m_hist, m_whist, m_dout;
    bit         p_valid, p_sof, p_weak;
    logic [7:0] p_data;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_hits = 0; m_miss = 0; m_ferr = 0;
        m_hist = 8'h00; m_whist = 8'h00; m_dout = 8'h00;
        p_valid = 0; p_sof = 0; p_weak = 0; p_data = 8'h00;
    endtask

    task automatic model_step(input bit b, input bit wk, output bit v,
                              output bit s, output bit w,
                              output logic [7:0] d);
        int slot;
        v = 0; s = 0; w = 0; d = 8'h00;
        m_hist  = {m_hist[6:0], b};
        m_whist = {m_whist[6:0], wk};
        if (m_mode == 0) begin
            if (m_hist == SW) begin
                m_mode = (VC == 1) ? 2 : 1;
                m_pos = 0; m_hits = 1; m_miss = 0;
            end
        end else begin
            m_pos++;
            if (m_pos % 8 == 0) begin
                slot  = (m_pos / 8) % FL;
                m_pos = m_pos % (8 * FL);
                if (slot == 0 && m_mode == 1) begin
                    if (m_hist == SW) begin
                        m_hits++;
                        if (m_hits == VC) begin m_mode = 2; m_miss = 0; end
                    end else begin
                        m_mode = 0; m_hits = 0;
                    end
                end else if (slot == 0) begin
                    if (m_hist == SW) m_miss = 0;
                    else begin
                        m_miss++;
                        if (m_ferr < 255) m_ferr++;
                        if (m_miss == LC) m_mode = 0;
                    end
                end else if (m_mode == 2) begin
                    v = 1; s = (slot == 1); w = |m_whist; d = m_hist;
                end
            end
        end
    endtask

    task automatic tick(input bit se, input bit b, input bit wk);
        bit         n_valid, n_sof, n_weak;
        logic [7:0] n_data;
        n_valid = 0; n_sof = 0; n_weak = 0; n_data = 8'h00;
        @(negedge clk);
        sample_en = se;
        d_bb      = b;
        d_q2      = wk ? 2'($urandom_range(1, 2)) : (b ? 2'b11 : 2'b00);
        @(posedge clk);
        #1;
        if (se) model_step(b, wk, n_valid, n_sof, n_weak, n_data);
        if (p_valid) m_dout = p_data;
        chk("data_valid", 32'(data_valid), 32'(p_valid));
        chk("sof", 32'(sof), 32'(p_sof));
        chk("byte_weak", 32'(byte_weak), 32'(p_weak));
        chk("data_out", 32'(data_out), 32'(m_dout));
        chk("state", 32'(state), 32'(m_mode));
        chk("locked", 32'(locked), 32'(m_mode == 2));
        chk("frame_err_cnt", 32'(frame_err_cnt), 32'(m_ferr));
        p_valid = n_valid; p_sof = n_sof; p_weak = n_weak; p_data = n_data;
    endtask

    task automatic send_bit(input bit b, input bit wk, input bit b2b);
        tick(1'b1, b, wk);
        if (!b2b) tick(1'b0, b, 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] v, input int wbit,
                             input bit b2b);
        for (int i = 0; i < 8; i++) send_bit(v[7-i], i == wbit, b2b);
    endtask

    task automatic pay3(input bit b2b);
        send_byte(8'h11, -1, b2b);
        send_byte(8'h22, -1, b2b);
        send_byte(8'h33, -1, b2b);
    endtask

    initial begin
        rst = 1'b1; sample_en = 1'b0; d_bb = 1'b0; d_q2 = 2'b00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", 32'(state), 32'h0);
        chk("rst_locked", 32'(locked), 32'h0);
        chk("rst_valid", {sof, byte_weak, data_valid}, 32'h0);
        chk("rst_dout", 32'(data_out), 32'h0);
        chk("rst_ferr", 32'(frame_err_cnt), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // clean acquisition
        repeat (8) send_bit(1'b0, 1'b0, 1'b0);
        send_byte(SW, -1, 0);
        chk("hunt_to_verify", 32'(state), 32'h1);
        pay3(0);
        send_byte(SW, -1, 0);
        chk("verify_hit2", 32'(state), 32'h1);
        pay3(0);
        send_byte(SW, -1, 0);
        chk("lock_3rd_sync", {locked, 6'd0, state}, {1'b1, 6'd0, 2'b10});
        send_byte(8'h11, -1, 0);
        chk("sof_first", {data_valid, sof, data_out}, {1'b1, 1'b1, 8'h11});
        send_byte(8'h22, -1, 0);
        chk("payload_22", {data_valid, sof, data_out}, {1'b1, 1'b0, 8'h22});
        send_byte(8'h33, -1, 0);

        // single sync miss while locked
        send_byte(8'hA4, -1, 0);
        chk("one_miss", {locked, frame_err_cnt}, {1'b1, 8'd1});
        chk("sync_no_valid", 32'(data_valid), 32'h0);
        pay3(0);

        // weak symbol on bit 4 of byte 22
        send_byte(SW, -1, 0);
        send_byte(8'h11, -1, 0);
        send_byte(8'h22, 4, 0);
        chk("weak_22", {data_valid, byte_weak, data_out}, {1'b1, 1'b1, 8'h22});
        send_byte(8'h33, -1, 0);
        chk("strong_33", {data_valid, byte_weak}, {1'b1, 1'b0});

        // back-to-back strobes
        send_byte(SW, -1, 1);
        pay3(1);
        send_byte(SW, -1, 0);
        pay3(0);

        // two consecutive sync misses
        send_byte(8'hA4, -1, 0);
        chk("miss1_held", {locked, frame_err_cnt}, {1'b1, 8'd2});
        pay3(0);
        send_byte(8'hA4, -1, 0);
        chk("loss_state", {locked, data_valid, 6'd0, state}, 32'h0);
        chk("loss_ferr", 32'(frame_err_cnt), 32'd3);

        // sync miss in verify, then fresh acquisition
        repeat (8) send_bit(1'b0, 1'b0, 1'b0);
        send_byte(SW, -1, 0);
        pay3(0);
        send_byte(8'h00, -1, 0);
        chk("verify_miss", 32'(state), 32'h0);
        pay3(0);
        send_byte(SW, -1, 0);
        chk("fresh_hit1", 32'(state), 32'h1);
        pay3(0);
        send_byte(SW, -1, 0);
        chk("fresh_hit2", 32'(state), 32'h1);
        pay3(0);
        send_byte(SW, -1, 0);
        chk("fresh_lock", 32'(state), 32'h2);

        // reset during bit 5 of a payload byte
        send_byte(8'h11, -1, 0);
        for (int i = 0; i < 5; i++) send_bit(i[0], 1'b0, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_outs", {data_valid, sof, byte_weak, locked, state}, 32'h0);
        chk("mid_rst_data", {frame_err_cnt, data_out}, 32'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        pay3(0);
        send_byte(SW, -1, 0);
        chk("reacq_verify", 32'(state), 32'h1);
        pay3(0);
        send_byte(SW, -1, 0);
        pay3(0);
        send_byte(SW, -1, 0);
        chk("reacq_lock", 32'(locked), 32'h1);

        // random frames
        for (int f = 0; f < 30; f++) begin
            logic [7:0] s;
            bit         bb;
            s  = ($urandom_range(0, 6) == 0) ? SW ^ 8'(1 << $urandom_range(0, 7)) : SW;
            bb = 1'($urandom_range(0, 1));
            send_byte(s, -1, bb);
            for (int k = 1; k < FL; k++)
                send_byte(8'($urandom_range(0, 255)), $urandom_range(0, 15), bb);
        end
        tick(1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
